// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver slice.
//   rx_state_e         : receiver FSM state encoding
//   DATA_WIDTH_DEF     : default number of data bits per frame
//   PRESCALE_8/16/32   : legal oversampling ratios (CLK cycles per bit)
//   sanitize_prescale  : maps an illegal ratio onto a legal one
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   localparam int unsigned DATA_WIDTH_DEF = 8;

   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   // Illegal ratios are forced to 16 so the bit timing always has room for
   // the three mid-bit samples and the counters can never stall.
   function automatic logic [5:0] sanitize_prescale(input logic [5:0] p);
      if (p inside {PRESCALE_8, PRESCALE_16, PRESCALE_32}) begin
         return p;
      end
      return PRESCALE_16;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Bit timing and sampling for the UART receiver.
//   clk_i       : oversampling clock
//   rst_i       : asynchronous active-high reset
//   run_i       : frame in progress (includes the start-detect cycle)
//   clr_i       : frame ends this cycle, bit counter returns to 0
//   rx_i        : serial line
//   prescale_i  : CLK cycles per bit (already legal)
//   wrap_o      : last edge count of the current bit
//   bit_cnt_o   : index of the current bit within the frame (start = 0)
//   bit_o       : majority of the three mid-bit samples
// -----------------------------------------------------------------------------
module uart_rx_sampler #(
   parameter int unsigned BIT_CNT_W = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 run_i,
   input  logic                 clr_i,
   input  logic                 rx_i,
   input  logic [5:0]           prescale_i,
   output logic                 wrap_o,
   output logic [BIT_CNT_W-1:0] bit_cnt_o,
   output logic                 bit_o
);

   logic [5:0]           edge_cnt_q, edge_cnt_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]           smp_q, smp_d;
   logic [5:0]           half;
   logic                 sample_now;

   assign half       = prescale_i >> 1;
   assign wrap_o     = run_i && (edge_cnt_q == prescale_i - 6'd1);
   assign sample_now = run_i && ((edge_cnt_q == half - 6'd1) ||
                                 (edge_cnt_q == half) ||
                                 (edge_cnt_q == half + 6'd1));

   always_comb begin
      edge_cnt_d = edge_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      smp_d      = smp_q;
      if (!run_i) begin
         edge_cnt_d = '0;
      end else if (wrap_o) begin
         edge_cnt_d = '0;
      end else begin
         edge_cnt_d = edge_cnt_q + 6'd1;
      end
      if (!run_i || clr_i) begin
         bit_cnt_d = '0;
      end else if (wrap_o) begin
         bit_cnt_d = bit_cnt_q + 1'b1;
      end
      if (sample_now) begin
         smp_d = {smp_q[1:0], rx_i};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
         smp_q      <= '1;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         smp_q      <= smp_d;
      end
   end

   assign bit_cnt_o = bit_cnt_q;
   assign bit_o     = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: start, DATA_WIDTH data bits LSB first, optional parity, stop.
//   CLK        : oversampling clock
//   RST        : asynchronous active-high reset
//   RX_IN      : serial line, idle high, synchronous to CLK
//   PRESCALE   : CLK cycles per bit (8, 16 or 32), latched at frame start
//   PAR_EN     : frame carries a parity bit, latched at frame start
//   PAR_TYP    : 1 = even, 0 = odd parity, latched at frame start
//   P_DATA     : last correctly received word
//   DATA_VALID : one-cycle pulse when P_DATA is updated
//   PAR_ERR    : one-cycle pulse on parity mismatch
//   STP_ERR    : one-cycle pulse when the stop bit is sampled low
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            PRESCALE,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_ERR,
   output logic                  STP_ERR
);

   localparam int unsigned BCW = $clog2(DATA_WIDTH + 3);
   localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH);

   rx_state_e             state_q, state_d;
   logic [5:0]            presc_q, presc_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  par_bad_q, par_bad_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  dv_q, dv_d;
   logic                  pe_q, pe_d;
   logic                  se_q, se_d;

   logic                  start_det;
   logic                  run;
   logic                  frame_done;
   logic [5:0]            presc_eff;
   logic                  wrap;
   logic [BCW-1:0]        bit_cnt;
   logic                  bit_val;
   logic                  calc_par;
   logic [DATA_WIDTH:0]   shifted;

   // The start-detect cycle itself is edge count 0 of the start bit, so the
   // sampler runs in that cycle using the live PRESCALE value.
   assign start_det  = (state_q == ST_IDLE) && !RX_IN;
   assign run        = (state_q != ST_IDLE) || start_det;
   assign presc_eff  = (state_q == ST_IDLE) ? sanitize_prescale(PRESCALE) : presc_q;
   assign frame_done = (state_q != ST_IDLE) && (state_d == ST_IDLE);
   assign calc_par   = par_typ_q ? (^shift_q) : ~(^shift_q);
   assign shifted    = {bit_val, shift_q};

   uart_rx_sampler #(
      .BIT_CNT_W (BCW)
   ) u_sampler (
      .clk_i      (CLK),
      .rst_i      (RST),
      .run_i      (run),
      .clr_i      (frame_done),
      .rx_i       (RX_IN),
      .prescale_i (presc_eff),
      .wrap_o     (wrap),
      .bit_cnt_o  (bit_cnt),
      .bit_o      (bit_val)
   );

   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      par_bad_d = par_bad_q;
      shift_d   = shift_q;
      p_data_d  = p_data_q;
      dv_d      = 1'b0;
      pe_d      = 1'b0;
      se_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_det) begin
               state_d   = ST_START;
               presc_d   = sanitize_prescale(PRESCALE);
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
               par_bad_d = 1'b0;
            end
         end
         ST_START: begin
            if (wrap) begin
               state_d = bit_val ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (wrap) begin
               shift_d = shifted[DATA_WIDTH:1];
               if (bit_cnt == LAST_DATA) begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            if (wrap) begin
               state_d = ST_STOP;
               if (bit_val != calc_par) begin
                  pe_d      = 1'b1;
                  par_bad_d = 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (wrap) begin
               state_d = ST_IDLE;
               if (!bit_val) begin
                  se_d = 1'b1;
               end else if (!par_bad_q) begin
                  p_data_d = shift_q;
                  dv_d     = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         presc_q   <= PRESCALE_16;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         par_bad_q <= 1'b0;
         shift_q   <= '0;
         p_data_q  <= '0;
         dv_q      <= 1'b0;
         pe_q      <= 1'b0;
         se_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         par_bad_q <= par_bad_d;
         shift_q   <= shift_d;
         p_data_q  <= p_data_d;
         dv_q      <= dv_d;
         pe_q      <= pe_d;
         se_q      <= se_d;
      end
   end

   assign P_DATA     = p_data_q;
   assign DATA_VALID = dv_q;
   assign PAR_ERR    = pe_q;
   assign STP_ERR    = se_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001: Parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002: CLK  input  1  oversampling clock; all state updates on its rising edge.
REQ-003: RST  input  1  reset, asynchronous and active-high; one clock, no other clock domains.
REQ-004: RX_IN  input  1  serial line, idle high; already synchronous to CLK.
REQ-005: PRESCALE  input  6  oversampling ratio, CLK cycles per bit; legal values 8, 16, 32.
REQ-006: PAR_EN  input  1  1 = frame carries a parity bit.
REQ-007: PAR_TYP  input  1  parity type: 1 = even, 0 = odd, matching the UART_TOP transmitter.
REQ-008: P_DATA  output  DATA_WIDTH  last correctly received data word.
REQ-009: DATA_VALID  output  1  one-cycle pulse, P_DATA updated with a good frame.
REQ-010: PAR_ERR  output  1  one-cycle pulse, parity mismatch.
REQ-011: STP_ERR  output  1  one-cycle pulse, stop bit sampled low.

Function
REQ-012: Frame format: start bit 0; DATA_WIDTH data bits, LSB first; parity bit only if PAR_EN; one stop bit 1.
REQ-013: FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on RX_IN = 0.
- START -> DATA after one bit time.
- DATA -> PARITY (PAR_EN = 1) or STOP (PAR_EN = 0) after DATA_WIDTH bit times.
- PARITY -> STOP after one bit time.
- STOP -> IDLE after one bit time.
REQ-014: Edge counter runs 0..PRESCALE-1 per bit, starting at 0 on the IDLE->START transition; bit counter advances on edge counter wrap.
REQ-015: Each bit value is the majority of RX_IN sampled at edge counts PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
REQ-016: Start-glitch rule: if the START majority is 1, the FSM returns to IDLE at the end of that bit time and produces no output pulse.
REQ-017: PRESCALE, PAR_EN and PAR_TYP are latched on the IDLE->START transition and held constant for the frame.
REQ-018: The parity check compares the sampled parity bit with XOR of the data bits (even) or XNOR of the data bits (odd).
REQ-019: PAR_ERR pulses for one cycle at edge count PRESCALE-1 of the parity bit on mismatch; the frame still runs through STOP.
REQ-020: At edge count PRESCALE-1 of the stop bit:
- stop bit 0 -> STP_ERR pulses for one cycle;
- no parity error and no stop error in the frame -> P_DATA is loaded and DATA_VALID pulses for one cycle in the same cycle.
REQ-021: P_DATA holds its value until the next good frame; errored frames never modify P_DATA.
REQ-022: Back-to-back frames: if RX_IN is 0 in the first cycle after STOP->IDLE, a new frame starts with no lost bits.
REQ-023: Illegal PRESCALE values do not hang the FSM; frames received with an illegal PRESCALE have undefined data content.

Reset
REQ-024: While RST is high: FSM in IDLE, both counters 0, P_DATA = 0, DATA_VALID = 0, PAR_ERR = 0, STP_ERR = 0.
REQ-025: RST asserted mid-frame aborts the frame immediately with no output pulse; reception resumes at the next falling edge of RX_IN after RST deasserts.

Structure
REQ-026: Package uart_pkg holds the FSM state enum, the DATA_WIDTH default and the legal PRESCALE constants (8, 16, 32).
REQ-027: Sub-module uart_rx_sampler holds the edge counter, the bit counter and the 3-sample majority voter; uart_rx holds the FSM, the shift register and the parity/stop checks.

Verification
REQ-028: PRESCALE = 8, PAR_EN = 1, PAR_TYP = 1, frame 0x75 with even parity bit 1 -> DATA_VALID pulse, P_DATA = 0x75, no error pulses.
REQ-029: PRESCALE = 16, PAR_EN = 1, PAR_TYP = 0, frame 0xE5 with a wrong parity bit -> PAR_ERR pulse, no DATA_VALID, P_DATA unchanged.
REQ-030: PRESCALE = 32, PAR_EN = 0, frame 0x46 with stop bit 0 -> STP_ERR pulse, no DATA_VALID.
REQ-031: 2-cycle low glitch on idle RX_IN -> FSM back in IDLE, no output pulses; a following valid frame 0x55 is received correctly.
REQ-032: Frames 0x75 then 0x55 back to back -> two DATA_VALID pulses exactly 11 x PRESCALE cycles apart (PAR_EN = 1).
REQ-033: RST asserted during the DATA state -> all outputs 0 immediately; the next full frame 0xA3 is received correctly.
